// File: rtl/amb_paylasim_hakemi_pkg.sv
// Shared definitions: ALU control encodings and the requester tags used by the arbiter,
// its output buffer and any driver/test code.
package amb_paylasim_hakemi_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_kontrol_e;

  localparam logic AMB_KIMLIK_BORU     = 1'b0;
  localparam logic AMB_KIMLIK_YARDIMCI = 1'b1;

endpackage

// File: rtl/amb_rr_hakem.sv
// Two-input round-robin grant with its priority pointer; combinational grant,
// pointer moves to the other requester only on an accepted operation.
module amb_rr_hakem
  import amb_paylasim_hakemi_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] gecerli_i,
  input  logic       kabul_i,
  output logic       secim_o,
  output logic       oncelik_o
);

  logic oncelik_q, oncelik_d;

  // With nobody or everybody requesting, the preferred requester is selected,
  // so the ALU inputs are always driven from a defined source.
  always_comb begin
    secim_o = oncelik_q;
    case (gecerli_i)
      2'b01:   secim_o = AMB_KIMLIK_BORU;
      2'b10:   secim_o = AMB_KIMLIK_YARDIMCI;
      default: secim_o = oncelik_q;
    endcase
  end

  always_comb begin
    oncelik_d = oncelik_q;
    if (kabul_i) oncelik_d = ~secim_o;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) oncelik_q <= AMB_KIMLIK_BORU;
    else       oncelik_q <= oncelik_d;
  end

  assign oncelik_o = oncelik_q;

endmodule

// File: rtl/amb_paylasim_hakemi.sv
// Round-robin sharing of one combinational ALU between two requesters, result in a
// one-entry valid/ready buffer. Optional counters: define AMB_PAYLASIM_SAYAC_EN.
module amb_paylasim_hakemi
  import amb_paylasim_hakemi_pkg::*;
#(
  parameter int VERI_GENISLIGI  = 32,
  parameter int SAYAC_GENISLIGI = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      ist0_gecerli_i,
  output logic                      ist0_hazir_o,
  input  logic [3:0]                ist0_kontrol_i,
  input  logic [VERI_GENISLIGI-1:0] ist0_deger1_i,
  input  logic [VERI_GENISLIGI-1:0] ist0_deger2_i,
  input  logic [1:0]                ist0_lt_ltu_i,
  input  logic                      ist1_gecerli_i,
  output logic                      ist1_hazir_o,
  input  logic [3:0]                ist1_kontrol_i,
  input  logic [VERI_GENISLIGI-1:0] ist1_deger1_i,
  input  logic [VERI_GENISLIGI-1:0] ist1_deger2_i,
  input  logic [1:0]                ist1_lt_ltu_i,
  output logic [3:0]                amb_kontrol_o,
  output logic [VERI_GENISLIGI-1:0] amb_deger1_o,
  output logic [VERI_GENISLIGI-1:0] amb_deger2_o,
  output logic [1:0]                amb_lt_ltu_o,
  input  logic [VERI_GENISLIGI-1:0] amb_sonuc_i,
  output logic                      sonuc_gecerli_o,
  input  logic                      sonuc_hazir_i,
  output logic [VERI_GENISLIGI-1:0] sonuc_o,
  output logic                      sonuc_kimlik_o
`ifdef AMB_PAYLASIM_SAYAC_EN
  ,
  output logic [SAYAC_GENISLIGI-1:0] sayac_ist0_o,
  output logic [SAYAC_GENISLIGI-1:0] sayac_ist1_o,
  output logic [SAYAC_GENISLIGI-1:0] sayac_cakisma_o
`endif
);

  logic                      secim, oncelik, bos, kabul;
  logic                      gecerli_q, gecerli_d;
  logic                      kimlik_q, kimlik_d;
  logic [VERI_GENISLIGI-1:0] sonuc_q, sonuc_d;

  amb_rr_hakem u_hakem (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .gecerli_i ({ist1_gecerli_i, ist0_gecerli_i}),
    .kabul_i   (kabul),
    .secim_o   (secim),
    .oncelik_o (oncelik)
  );

  // Draining and refilling in the same cycle keeps one op per cycle under no backpressure.
  assign bos   = !gecerli_q || sonuc_hazir_i;
  assign kabul = bos && ((secim == AMB_KIMLIK_YARDIMCI) ? ist1_gecerli_i : ist0_gecerli_i);

  assign ist0_hazir_o = kabul && (secim == AMB_KIMLIK_BORU);
  assign ist1_hazir_o = kabul && (secim == AMB_KIMLIK_YARDIMCI);

  assign amb_kontrol_o = (secim == AMB_KIMLIK_YARDIMCI) ? ist1_kontrol_i : ist0_kontrol_i;
  assign amb_deger1_o  = (secim == AMB_KIMLIK_YARDIMCI) ? ist1_deger1_i  : ist0_deger1_i;
  assign amb_deger2_o  = (secim == AMB_KIMLIK_YARDIMCI) ? ist1_deger2_i  : ist0_deger2_i;
  assign amb_lt_ltu_o  = (secim == AMB_KIMLIK_YARDIMCI) ? ist1_lt_ltu_i  : ist0_lt_ltu_i;

  always_comb begin
    gecerli_d = gecerli_q;
    kimlik_d  = kimlik_q;
    sonuc_d   = sonuc_q;
    if (kabul) begin
      gecerli_d = 1'b1;
      kimlik_d  = secim;
      sonuc_d   = amb_sonuc_i;
    end else if (sonuc_hazir_i) begin
      gecerli_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gecerli_q <= 1'b0;
      kimlik_q  <= AMB_KIMLIK_BORU;
      sonuc_q   <= '0;
    end else begin
      gecerli_q <= gecerli_d;
      kimlik_q  <= kimlik_d;
      sonuc_q   <= sonuc_d;
    end
  end

  assign sonuc_gecerli_o = gecerli_q;
  assign sonuc_o         = sonuc_q;
  assign sonuc_kimlik_o  = kimlik_q;

`ifdef AMB_PAYLASIM_SAYAC_EN
  logic [SAYAC_GENISLIGI-1:0] sayac_ist0_q, sayac_ist1_q, sayac_cakisma_q;

  // Contention counts every both-valid cycle, whether it ended in a grant or a stall.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sayac_ist0_q    <= '0;
      sayac_ist1_q    <= '0;
      sayac_cakisma_q <= '0;
    end else begin
      if (ist0_hazir_o)                    sayac_ist0_q    <= sayac_ist0_q + 1'b1;
      if (ist1_hazir_o)                    sayac_ist1_q    <= sayac_ist1_q + 1'b1;
      if (ist0_gecerli_i && ist1_gecerli_i) sayac_cakisma_q <= sayac_cakisma_q + 1'b1;
    end
  end

  assign sayac_ist0_o    = sayac_ist0_q;
  assign sayac_ist1_o    = sayac_ist1_q;
  assign sayac_cakisma_o = sayac_cakisma_q;
`else
  logic [SAYAC_GENISLIGI-1:0] sayac_unused;
  assign sayac_unused = '0;
`endif

  logic oncelik_unused;
  assign oncelik_unused = oncelik;

endmodule

// File: tb/tb_amb_paylasim_hakemi.sv
// Directed, table-driven bench for the shared-ALU arbiter, with an external ALU model
// driving amb_sonuc_i and hand-written sequences for reset, stall and cancel cases.
module tb_amb_paylasim_hakemi;
  import amb_paylasim_hakemi_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        v0, v1, rdy;
  logic [3:0]  k0, k1;
  logic [31:0] a0, b0, a1, b1;
  logic [1:0]  f0, f1;
  logic        h0, h1;
  logic [3:0]  amb_k;
  logic [31:0] amb_a, amb_b, amb_s;
  logic [1:0]  amb_f;
  logic        sv, kim;
  logic [31:0] res;
`ifdef AMB_PAYLASIM_SAYAC_EN
  logic [31:0] c0, c1, cc;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  amb_paylasim_hakemi dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .ist0_gecerli_i (v0),
    .ist0_hazir_o   (h0),
    .ist0_kontrol_i (k0),
    .ist0_deger1_i  (a0),
    .ist0_deger2_i  (b0),
    .ist0_lt_ltu_i  (f0),
    .ist1_gecerli_i (v1),
    .ist1_hazir_o   (h1),
    .ist1_kontrol_i (k1),
    .ist1_deger1_i  (a1),
    .ist1_deger2_i  (b1),
    .ist1_lt_ltu_i  (f1),
    .amb_kontrol_o  (amb_k),
    .amb_deger1_o   (amb_a),
    .amb_deger2_o   (amb_b),
    .amb_lt_ltu_o   (amb_f),
    .amb_sonuc_i    (amb_s),
    .sonuc_gecerli_o(sv),
    .sonuc_hazir_i  (rdy),
    .sonuc_o        (res),
    .sonuc_kimlik_o (kim)
`ifdef AMB_PAYLASIM_SAYAC_EN
    ,
    .sayac_ist0_o   (c0),
    .sayac_ist1_o   (c1),
    .sayac_cakisma_o(cc)
`endif
  );

  // External ALU: a small subset of operations is enough for these vectors.
  always_comb begin
    amb_s = 32'h0;
    case (amb_k)
      ALU_ADD: amb_s = amb_a + amb_b;
      ALU_SUB: amb_s = amb_a - amb_b;
      ALU_AND: amb_s = amb_a & amb_b;
      ALU_OR:  amb_s = amb_a | amb_b;
      ALU_XOR: amb_s = amb_a ^ amb_b;
      default: amb_s = 32'h0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic vv0, input logic [3:0] kk0, input logic [31:0] aa0,
                         input logic [31:0] bb0, input logic vv1, input logic [3:0] kk1,
                         input logic [31:0] aa1, input logic [31:0] bb1, input logic r);
    v0 = vv0; k0 = kk0; a0 = aa0; b0 = bb0;
    v1 = vv1; k1 = kk1; a1 = aa1; b1 = bb1;
    rdy = r;
  endtask

  typedef struct {
    logic        v0;
    logic [3:0]  k0;
    logic [31:0] a0, b0;
    logic        v1;
    logic [3:0]  k1;
    logic [31:0] a1, b1;
    logic        rdy;
    logic        eh0, eh1, esv;
    logic [31:0] eres;
    logic        ekim;
  } vek_t;

  vek_t vt[12];

  initial begin
    // v0 k0 a0 b0 | v1 k1 a1 b1 | rdy | hazir0 hazir1 | next: gecerli sonuc kimlik
    vt[0]  = '{1'b1, ALU_ADD, 32'd5,  32'd7,  1'b0, ALU_ADD, 32'd0,     32'd0,  1'b1, 1'b1, 1'b0, 1'b1, 32'd12,        1'b0};
    vt[1]  = '{1'b1, ALU_SUB, 32'd5,  32'd7,  1'b0, ALU_ADD, 32'd0,     32'd0,  1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0};
    vt[2]  = '{1'b1, ALU_ADD, 32'd1,  32'd2,  1'b1, ALU_XOR, 32'hF0,    32'h0F, 1'b1, 1'b0, 1'b1, 1'b1, 32'hFF,        1'b1};
    vt[3]  = '{1'b1, ALU_ADD, 32'd1,  32'd2,  1'b1, ALU_OR,  32'h100,   32'h1,  1'b1, 1'b1, 1'b0, 1'b1, 32'd3,         1'b0};
    vt[4]  = '{1'b1, ALU_ADD, 32'd10, 32'd20, 1'b1, ALU_OR,  32'h100,   32'h1,  1'b1, 1'b0, 1'b1, 1'b1, 32'h101,       1'b1};
    vt[5]  = '{1'b1, ALU_ADD, 32'd10, 32'd20, 1'b1, ALU_SUB, 32'd100,   32'd1,  1'b1, 1'b1, 1'b0, 1'b1, 32'd30,        1'b0};
    vt[6]  = '{1'b1, ALU_ADD, 32'd2,  32'd2,  1'b1, ALU_SUB, 32'd100,   32'd1,  1'b0, 1'b0, 1'b0, 1'b1, 32'd30,        1'b0};
    vt[7]  = '{1'b1, ALU_ADD, 32'd2,  32'd2,  1'b1, ALU_SUB, 32'd100,   32'd1,  1'b0, 1'b0, 1'b0, 1'b1, 32'd30,        1'b0};
    vt[8]  = '{1'b1, ALU_ADD, 32'd2,  32'd2,  1'b1, ALU_SUB, 32'd100,   32'd1,  1'b0, 1'b0, 1'b0, 1'b1, 32'd30,        1'b0};
    vt[9]  = '{1'b1, ALU_ADD, 32'd2,  32'd2,  1'b1, ALU_SUB, 32'd100,   32'd1,  1'b1, 1'b0, 1'b1, 1'b1, 32'd99,        1'b1};
    vt[10] = '{1'b1, ALU_ADD, 32'd2,  32'd2,  1'b0, ALU_SUB, 32'd100,   32'd1,  1'b1, 1'b1, 1'b0, 1'b1, 32'd4,         1'b0};
    vt[11] = '{1'b0, ALU_ADD, 32'd2,  32'd2,  1'b0, ALU_SUB, 32'd100,   32'd1,  1'b1, 1'b0, 1'b0, 1'b0, 32'd4,         1'b0};

    rst = 1'b1;
    f0 = 2'b01; f1 = 2'b10;
    set_req(1'b0, ALU_ADD, 32'd0, 32'd0, 1'b0, ALU_ADD, 32'd0, 32'd0, 1'b0);
    step(); step();
    chk("reset_gecerli", {31'd0, sv}, 32'd0);
    chk("reset_sonuc", res, 32'd0);
    chk("reset_kimlik", {31'd0, kim}, 32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 12; i++) begin
      set_req(vt[i].v0, vt[i].k0, vt[i].a0, vt[i].b0, vt[i].v1, vt[i].k1, vt[i].a1, vt[i].b1, vt[i].rdy);
      #1;
      chk($sformatf("v%0d_hazir0", i), {31'd0, h0}, {31'd0, vt[i].eh0});
      chk($sformatf("v%0d_hazir1", i), {31'd0, h1}, {31'd0, vt[i].eh1});
      step();
      chk($sformatf("v%0d_gecerli", i), {31'd0, sv}, {31'd0, vt[i].esv});
      chk($sformatf("v%0d_sonuc", i), res, vt[i].eres);
      chk($sformatf("v%0d_kimlik", i), {31'd0, kim}, {31'd0, vt[i].ekim});
    end

`ifdef AMB_PAYLASIM_SAYAC_EN
    chk("sayac_ist0", c0, 32'd5);
    chk("sayac_ist1", c1, 32'd3);
    chk("sayac_cakisma", cc, 32'd8);
`endif

    // Idle: pointer is 1 after the last accept, so the ALU sees requester 1's fields.
    set_req(1'b0, ALU_ADD, 32'h11, 32'd0, 1'b0, ALU_XOR, 32'h22, 32'd0, 1'b1);
    #1;
    chk("idle_amb_deger1", amb_a, 32'h22);
    chk("idle_amb_kontrol", {28'd0, amb_k}, {28'd0, ALU_XOR});

    // Cancel: fill buffer from requester 0, requester 1 asks during the stall then drops.
    set_req(1'b1, ALU_ADD, 32'd1, 32'd1, 1'b0, ALU_XOR, 32'h22, 32'd0, 1'b0);
    step();
    chk("cancel_fill_sonuc", res, 32'd2);
    set_req(1'b0, ALU_ADD, 32'd1, 32'd1, 1'b1, ALU_XOR, 32'h22, 32'd0, 1'b0);
    #1;
    chk("cancel_stall_hazir1", {31'd0, h1}, 32'd0);
    step();
    v1 = 1'b0; rdy = 1'b1;
    #1;
    chk("cancel_drop_hazir1", {31'd0, h1}, 32'd0);
    step();
    chk("cancel_drained", {31'd0, sv}, 32'd0);
    chk("cancel_kimlik", {31'd0, kim}, 32'd0);
    set_req(1'b1, ALU_ADD, 32'd3, 32'd3, 1'b1, ALU_SUB, 32'd9, 32'd4, 1'b1);
    #1;
    chk("cancel_ptr_hazir1", {31'd0, h1}, 32'd1);
    chk("cancel_ptr_hazir0", {31'd0, h0}, 32'd0);
    step();
    chk("cancel_ptr_sonuc", res, 32'd5);

    // Reset while the buffer is full and stalled.
    rdy = 1'b0;
    step();
    chk("pre_reset_gecerli", {31'd0, sv}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_reset_gecerli", {31'd0, sv}, 32'd0);
    chk("async_reset_sonuc", res, 32'd0);
    step();
    rst = 1'b0;
    rdy = 1'b1;
    #1;
    chk("post_reset_hazir0", {31'd0, h0}, 32'd1);
    chk("post_reset_hazir1", {31'd0, h1}, 32'd0);
    step();
    chk("post_reset_sonuc", res, 32'd6);
    chk("post_reset_kimlik", {31'd0, kim}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/amb_paylasim_hakemi.md
Name: amb_paylasim_hakemi

Overview:
- Shares one combinational ALU (4-bit control, two 32-bit operands, 2-bit lt/ltu flags) between two requesters.
- Requester 0 is the execute stage of the pipeline; requester 1 is an auxiliary unit, e.g. address/CSR helper.
- Round-robin arbitration drives the ALU inputs and registers the ALU result into a one-entry output buffer.
- The output buffer carries a requester tag and uses a valid/ready handshake.

Parameters:
- VERI_GENISLIGI, 32, operand/result width.
- SAYAC_GENISLIGI, 32, width of the optional performance counters.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- ist0_gecerli_i  input  1  requester 0 has an operation.
- ist0_hazir_o  output  1  requester 0 operation accepted this cycle.
- ist0_kontrol_i  input  4  ALU operation code for requester 0.
- ist0_deger1_i  input  32  operand 1 for requester 0.
- ist0_deger2_i  input  32  operand 2 for requester 0.
- ist0_lt_ltu_i  input  2  comparison flags for requester 0.
- ist1_gecerli_i, ist1_hazir_o, ist1_kontrol_i, ist1_deger1_i, ist1_deger2_i, ist1_lt_ltu_i: same directions, widths and meanings, for requester 1.
- amb_kontrol_o  output  4  to the shared ALU.
- amb_deger1_o  output  32  to the shared ALU.
- amb_deger2_o  output  32  to the shared ALU.
- amb_lt_ltu_o  output  2  to the shared ALU.
- amb_sonuc_i  input  32  ALU result, combinational in the same cycle.
- sonuc_gecerli_o  output  1  output buffer full.
- sonuc_hazir_i  input  1  consumer takes the result.
- sonuc_o  output  32  registered result.
- sonuc_kimlik_o  output  1  requester that produced sonuc_o.

Behaviour:
- Reset (async, rst_i=1), regardless of in-flight operation:
  - sonuc_gecerli_o=0, sonuc_o=0, sonuc_kimlik_o=0.
  - Priority pointer oncelik=0 (requester 0 preferred).
  - Any buffered result is discarded.
- Buffer availability: bos = !sonuc_gecerli_o || sonuc_hazir_i. This allows full throughput of one op per cycle when the consumer is always ready.
- Grant, combinational:
  - Only one requester valid: it wins.
  - Both valid: requester == oncelik wins.
  - kabul = bos && winner valid. ist*_hazir_o = kabul for the winner; the loser sees 0.
  - With bos=0, both hazir outputs are 0.
- ALU drive:
  - amb_* outputs carry the winner's fields every cycle, even without kabul.
  - With no requester valid, amb_* carry requester oncelik's fields (no X; helps power/debug).
- On kabul, at the clock edge:
  - sonuc_o <= amb_sonuc_i; sonuc_kimlik_o <= winner; sonuc_gecerli_o <= 1.
  - oncelik <= ~winner, so the other requester is preferred next.
- Latency: request accepted in cycle N; result visible with sonuc_gecerli_o=1 in cycle N+1.
- Drain without a new kabul: sonuc_gecerli_o && sonuc_hazir_i && !kabul gives sonuc_gecerli_o <= 0.
- Simultaneous drain and accept: the buffer is overwritten with the new result and sonuc_gecerli_o stays 1.
- Stall: sonuc_gecerli_o=1 && sonuc_hazir_i=0 holds sonuc_o/sonuc_kimlik_o stable, with no grant.
- Requester rules: must hold valid and fields stable until hazir. Dropping valid before hazir is permitted (cancel); nothing is recorded.
- oncelik changes only on kabul. Stalls and idle cycles do not rotate it.
- Starvation bound: while both requesters are valid, each is granted within 2 accepted operations.

Optional Feature:
- Macro AMB_PAYLASIM_SAYAC_EN.
- Defined: adds output ports sayac_ist0_o, sayac_ist1_o, sayac_cakisma_o, each SAYAC_GENISLIGI wide, reset to 0.
  - sayac_ist0_o / sayac_ist1_o increment on a kabul for that requester.
  - sayac_cakisma_o increments on any cycle both valids are high (grant or stall).
  - All counters wrap modulo 2^SAYAC_GENISLIGI.
- Undefined: the ports and registers are absent; behaviour otherwise identical.

Decomposition:
- Shared header tanimlamalar.vh holds the ALU control encodings used by test/driver code and a new constant AMB_KIMLIK_BORU=0 / AMB_KIMLIK_YARDIMCI=1.
- One natural sub-module: amb_rr_hakem. It is a 2-input round-robin grant plus pointer register (inputs gecerli[1:0], kabul; outputs secim, pointer).
- Buffer and counters stay in the top.

Test Plan:
- Reset mid-operation: assert rst_i while sonuc_gecerli_o=1, ready=0 -> immediately sonuc_gecerli_o=0, sonuc_o=0; first post-reset contention grants requester 0.
- Single requester, consumer always ready: requester 0 sends ADD 5+7, then SUB 5-7 back-to-back -> ist0_hazir_o=1 both cycles. Next cycles: sonuc_o=12 then 0xFFFFFFFE, kimlik=0.
- Contention: both valid continuously for 4 ops, consumer ready -> grants alternate 0,1,0,1; sonuc_kimlik_o matches the sequence.
- Backpressure: buffer full, sonuc_hazir_i=0 for 3 cycles with both valid -> both hazir=0. Result and pointer stay unchanged. On ready=1 the drain and a new accept happen in the same cycle; sonuc_gecerli_o stays 1.
- Cancel: requester 1 valid during a stall, then drops before grant -> no grant to 1, oncelik unchanged, no result with kimlik=1.
- With AMB_PAYLASIM_SAYAC_EN: run the contention test -> sayac_ist0_o=2, sayac_ist1_o=2, sayac_cakisma_o=4. Preload a counter near max and verify it wraps to 0.
